// File: rtl/bcd_countdown_timer_if.sv
// Control and digit bundle for the BCD countdown timer.
// The master drives the control pulses and preset; the slave (the timer) drives the digits and status.
interface bcd_countdown_timer_if;
  logic        load;
  logic        start;
  logic        pause;
  logic [15:0] load_bcd;
  logic [3:0]  bcd3;
  logic [3:0]  bcd2;
  logic [3:0]  bcd1;
  logic [3:0]  bcd0;
  logic        running;
  logic        done;
  logic        expired;

  modport master (
    output load, start, pause, load_bcd,
    input  bcd3, bcd2, bcd1, bcd0, running, done, expired
  );

  modport slave (
    input  load, start, pause, load_bcd,
    output bcd3, bcd2, bcd1, bcd0, running, done, expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer: loads a preset and decrements it once per TICK_DIV clocks.
// It stops at 00.00, raises done as a level, and pulses expired for one cycle.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 500000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  bcd_countdown_timer_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   pre;
  logic [3:0][3:0] dig;
  logic [3:0][3:0] dig_dec;
  logic [3:0][3:0] dig_ld;
  logic            tick;
  logic            last;
  logic            running;
  logic            done;
  logic            expired;

  function automatic logic [3:0][3:0] bcd_dec(input logic [3:0][3:0] v);
    logic [3:0][3:0] r;
    logic            borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) r[i] = 4'd9;
        else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    dig_ld = '0;
    for (int i = 0; i < 4; i++)
      dig_ld[i] = (bus.load_bcd[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_bcd[4*i +: 4];
  end

  assign dig_dec = bcd_dec(dig);
  assign tick    = (state == RUN) && (pre == PW'(TICK_DIV - 1));
  assign last    = (dig == 16'h0001);

  // Prescaler only advances while in RUN and not leaving it, so pause/resume never adds drift.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      pre     <= '0;
      dig     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (bus.load) begin
        dig     <= dig_ld;
        state   <= IDLE;
        pre     <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pre <= '0;
            if (bus.start && dig != '0) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              pre <= '0;
              if (last) begin
                dig     <= '0;
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
                expired <= 1'b1;
              end else begin
                dig <= dig_dec;
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
          PAUSED: begin
            if (bus.start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            pre <= '0;
          end
        endcase
      end
    end
  end

  assign bus.bcd3    = dig[3];
  assign bus.bcd2    = dig[2];
  assign bus.bcd1    = dig[1];
  assign bus.bcd0    = dig[0];
  assign bus.running = running;
  assign bus.done    = done;
  assign bus.expired = expired;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for the BCD countdown timer with TICK_DIV = 4.
module tb_bcd_countdown_timer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bcd_countdown_timer_if bus();

  bcd_countdown_timer #(.TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1; bus.load_bcd = v;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(10);
    checks++;
    if (digits() !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits()); end
    checks++;
    if ({bus.running, bus.done, bus.expired} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.running, bus.done, bus.expired});
    end
    do_start();
    checks++;
    if (bus.running !== 1'b0) begin failures++; $display("FAIL start_at_zero running=%b exp=0", bus.running); end
  endtask

  task automatic test_countdown();
    logic [15:0] exp [4];
    logic [15:0] prev;
    exp = '{16'h0102, 16'h0101, 16'h0100, 16'h0099};
    do_load(16'h0103);
    do_start();
    checks++;
    if (bus.running !== 1'b1) begin failures++; $display("FAIL run_latency running=%b exp=1", bus.running); end
    prev = 16'h0103;
    for (int k = 0; k < 4; k++) begin
      step(3);
      checks++;
      if (digits() !== prev) begin failures++; $display("FAIL tick_early[%0d] got=%h exp=%h", k, digits(), prev); end
      step(1);
      checks++;
      if (digits() !== exp[k]) begin failures++; $display("FAIL tick[%0d] got=%h exp=%h", k, digits(), exp[k]); end
      prev = exp[k];
    end
  endtask

  task automatic test_expiry();
    do_load(16'h0002);
    do_start();
    step(4);
    checks++;
    if (digits() !== 16'h0001) begin failures++; $display("FAIL exp_first got=%h exp=0001", digits()); end
    step(3);
    checks++;
    if ({bus.running, bus.done} !== 2'b10) begin
      failures++; $display("FAIL exp_pre_flags got=%b exp=10", {bus.running, bus.done});
    end
    step(1);
    checks++;
    if (digits() !== 16'h0000) begin failures++; $display("FAIL exp_zero got=%h exp=0000", digits()); end
    checks++;
    if ({bus.running, bus.done, bus.expired} !== 3'b011) begin
      failures++; $display("FAIL exp_flags got=%b exp=011", {bus.running, bus.done, bus.expired});
    end
    for (int i = 0; i < 20; i++) begin
      bus.start = (i == 2);
      bus.pause = (i == 4);
      step(1);
      checks++;
      if ({digits(), bus.running, bus.done, bus.expired} !== {16'h0000, 3'b010}) begin
        failures++;
        $display("FAIL done_hold[%0d] got=%h/%b exp=0000/010", i, digits(), {bus.running, bus.done, bus.expired});
      end
    end
    bus.start = 1'b0; bus.pause = 1'b0;
  endtask

  task automatic test_pause();
    do_load(16'h0050);
    do_start();
    step(2);
    do_pause();
    checks++;
    if (bus.running !== 1'b0) begin failures++; $display("FAIL pause_running=%b exp=0", bus.running); end
    step(20);
    checks++;
    if (digits() !== 16'h0050) begin failures++; $display("FAIL pause_frozen got=%h exp=0050", digits()); end
    do_pause();
    checks++;
    if (bus.running !== 1'b0) begin failures++; $display("FAIL pause_noop running=%b exp=0", bus.running); end
    do_start();
    checks++;
    if ({digits(), bus.running} !== {16'h0050, 1'b1}) begin
      failures++; $display("FAIL resume got=%h/%b exp=0050/1", digits(), bus.running);
    end
    step(1);
    checks++;
    if (digits() !== 16'h0050) begin failures++; $display("FAIL resume_early got=%h exp=0050", digits()); end
    step(1);
    checks++;
    if (digits() !== 16'h0049) begin failures++; $display("FAIL resume_tick got=%h exp=0049", digits()); end
    step(4);
    checks++;
    if (digits() !== 16'h0048) begin failures++; $display("FAIL resume_period got=%h exp=0048", digits()); end
    bus.start = 1'b1; bus.pause = 1'b1;
    step(1);
    bus.start = 1'b0; bus.pause = 1'b0;
    checks++;
    if (bus.running !== 1'b0) begin failures++; $display("FAIL run_pause_wins running=%b exp=0", bus.running); end
  endtask

  task automatic test_load();
    do_load(16'hF0A5);
    checks++;
    if (digits() !== 16'h9095) begin failures++; $display("FAIL clamp got=%h exp=9095", digits()); end
    do_start();
    bus.load = 1'b1; bus.start = 1'b1; bus.load_bcd = 16'h1234;
    step(1);
    bus.load = 1'b0; bus.start = 1'b0;
    checks++;
    if ({digits(), bus.running} !== {16'h1234, 1'b0}) begin
      failures++; $display("FAIL load_beats_start got=%h/%b exp=1234/0", digits(), bus.running);
    end
    step(6);
    checks++;
    if (digits() !== 16'h1234) begin failures++; $display("FAIL idle_hold got=%h exp=1234", digits()); end
  endtask

  task automatic test_reset_mid_run();
    do_load(16'h0043);
    do_start();
    step(4);
    checks++;
    if (digits() !== 16'h0042) begin failures++; $display("FAIL mid_pre got=%h exp=0042", digits()); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({digits(), bus.running, bus.done, bus.expired} !== {16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b exp=0000/000", digits(), {bus.running, bus.done, bus.expired});
    end
    step(5);
    checks++;
    if ({digits(), bus.expired} !== {16'h0000, 1'b0}) begin
      failures++; $display("FAIL mid_reset_idle got=%h/%b exp=0000/0", digits(), bus.expired);
    end
    do_load(16'h9999);
    do_start();
    step(4);
    checks++;
    if (digits() !== 16'h9998) begin failures++; $display("FAIL after_reset got=%h exp=9998", digits()); end
    do_load(16'h1000);
    do_start();
    step(4);
    checks++;
    if (digits() !== 16'h0999) begin failures++; $display("FAIL full_borrow got=%h exp=0999", digits()); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.load_bcd = '0;
    test_reset();
    test_countdown();
    test_expiry();
    test_pause();
    test_load();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
